// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial adder controller: the 2-bit FSM
//   state encodings and the next-state decode function.
//   The encoding 2'd3 is unused; the decode sends it back to IDLE so a
//   corrupted state register always recovers.
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Next-state decode.
    //   IDLE -(start)-> RUN -(last bit)-> DONE -(always)-> IDLE
    function automatic logic [1:0] fsm_next(input logic [1:0] state,
                                            input logic       start,
                                            input logic       last_bit);
        logic [1:0] nxt;
        nxt = ST_IDLE;
        case (state)
            ST_IDLE: nxt = start    ? ST_RUN  : ST_IDLE;
            ST_RUN:  nxt = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/full_addr.sv
// -----------------------------------------------------------------------------
// full_addr
//   Single-bit full adder cell, purely combinational.
// Ports
//   a, b   in   operand bits
//   ci     in   carry in
//   sum    out  a ^ b ^ ci
//   carry  out  carry out
// -----------------------------------------------------------------------------
module full_addr (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic carry
);

    logic half;

    assign half  = a ^ b;
    assign sum   = half ^ ci;
    assign carry = (a & b) | (ci & half);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. One full_addr cell is stepped over two
//   WIDTH-bit operands, one bit per clock, LSB first, with the carry held in a
//   flip-flop between bits. {cout, sum_out} = a_in + b_in + cin.
//
//   Timing: accept on edge k (IDLE & start); bit edges k+1..k+WIDTH; done is
//   high for the one cycle after edge k+WIDTH; back in IDLE after edge
//   k+WIDTH+1. One add per WIDTH+2 cycles.
//
//   Handshake: start is a request sampled only in IDLE; the edge that samples
//   it high captures a_in/b_in/cin, after which the inputs may change freely.
//   start seen in RUN or DONE is dropped (no queueing). done is a one-cycle
//   completion pulse; sum_out/cout are valid from done and held until the
//   next completion or reset.
//
// Parameters
//   WIDTH      operand/result width, 2..32
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled in IDLE
//   a_in       in   operand A
//   b_in       in   operand B
//   cin        in   carry in
//   busy       out  high while in RUN
//   done       out  high for the single DONE cycle
//   sum_out    out  result
//   cout       out  final carry
//   dbg_state  out  current FSM state (ST_* encoding) for observation
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;
    logic [WIDTH-1:0] res_nxt;

    full_addr u_full_addr (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .ci    (c_reg),
        .sum   (bit_sum),
        .carry (bit_carry)
    );

    assign last_bit  = (cnt == LAST_BIT);
    assign state_nxt = fsm_next(state, start, last_bit);

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 of the
    // operands has landed in bit 0 of the result.
    assign res_nxt = {bit_sum, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        c_reg  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                ST_RUN: begin
                    res_sh <= res_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c_reg  <= bit_carry;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_out <= res_nxt;
                        cout    <= bit_carry;
                    end
                end
                default: begin
                    // DONE and the unused encoding only move the FSM.
                end
            endcase
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl. An 8-bit instance covers the
//   directed and randomized scenarios; a 3-bit instance is swept exhaustively.
//   Expected results come from plain integer addition; expected timing comes
//   from the documented latency (WIDTH busy cycles, one done cycle, one IDLE
//   cycle).
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- 8-bit DUT ----------------
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
    logic [1:0]   dbg_state;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .cout      (cout),
        .dbg_state (dbg_state)
    );

    // ---------------- 3-bit DUT ----------------
    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;
    logic [1:0] dbg3;

    serial_add_ctrl #(.WIDTH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .a_in      (a3),
        .b_in      (b3),
        .cin       (cin3),
        .busy      (busy3),
        .done      (done3),
        .sum_out   (sum3),
        .cout      (cout3),
        .dbg_state (dbg3)
    );

    // ---------------- scoreboard ----------------
    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [W:0]   prev_res;          // last completed {cout,sum_out}
    logic [W:0]   exp_q[$];

    function automatic logic [W:0] model_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic         c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;  a_in = '0; b_in = '0; cin = 1'b0;
        start3 = 1'b0;  a3 = '0;   b3 = '0;   cin3 = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, cout, sum_out} !== {3'b000, {W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum_out);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_res = '0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    // One complete add with latency, pulse width and hold checks.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input string name);
        logic [W:0] exp;
        int         busy_n;
        int         done_n;
        exp = model_add(a, b, c);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin = c;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom); b_in = W'($urandom); cin = 1'($urandom_range(0, 1));
        busy_n = 0;
        while (busy === 1'b1 && busy_n < 64) begin
            busy_n++;
            tests_run++;
            if ({cout, sum_out} !== prev_res) begin
                tests_failed++;
                $display("FAIL %s_hold: got %h want %h", name, {cout, sum_out}, prev_res);
            end
            @(negedge clk);
        end
        tests_run++;
        if (busy_n != W) begin
            tests_failed++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_n, W);
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_done: got %b want 1", name, done);
        end
        tests_run++;
        if ({cout, sum_out} !== exp) begin
            tests_failed++;
            $display("FAIL %s_result: got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum_out, exp[W], exp[W-1:0]);
        end
        prev_res = exp;
        done_n = 0;
        while (done === 1'b1 && done_n < 8) begin
            done_n++;
            @(negedge clk);
        end
        tests_run++;
        if (done_n != 1) begin
            tests_failed++;
            $display("FAIL %s_done_width: got %0d want 1", name, done_n);
        end
        tests_run++;
        if (busy !== 1'b0 || {cout, sum_out} !== exp) begin
            tests_failed++;
            $display("FAIL %s_after: busy=%b res=%h want busy=0 res=%h",
                     name, busy, {cout, sum_out}, exp);
        end
    endtask

    task automatic test_directed();
        run_add(8'h00, 8'h00, 1'b0, "zero");
        run_add(8'hFF, 8'h01, 1'b0, "wrap");
        run_add(8'hA5, 8'h5A, 1'b1, "a5_5a_c1");
        run_add(8'hFF, 8'hFF, 1'b1, "max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    // start pulsed mid-RUN with different operands must be dropped.
    task automatic test_ignore_start();
        int n;
        @(negedge clk);
        start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || {cout, sum_out} !== 9'h046) begin
            tests_failed++;
            $display("FAIL ignore_result: done=%b got %h want 046", done, {cout, sum_out});
        end
        prev_res = 9'h046;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL ignore_no_queue: busy=%b done=%b want 0 0", busy, done);
            end
        end
    endtask

    // Async reset in the 4th RUN cycle aborts without a done pulse.
    task automatic test_reset_mid_run();
        int seen_done;
        @(negedge clk);
        start = 1'b1; a_in = 8'h77; b_in = 8'h11; cin = 1'b1;
        @(negedge clk);       // 1st RUN cycle
        start = 1'b0;
        repeat (3) @(negedge clk);  // 4th RUN cycle
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, cout, sum_out} !== {3'b000, {W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL abort_outputs: busy=%b done=%b cout=%b sum=%h want all 0",
                     busy, done, cout, sum_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_res = '0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        tests_run++;
        if (seen_done != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", seen_done);
        end
        run_add(8'h03, 8'h04, 1'b0, "post_reset");
    endtask

    // start held high: an accept on every IDLE cycle, one add per W+2 cycles.
    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W:0]   exp;
        int           bad_busy;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_idle_%0d: busy=%b done=%b want 0 0", i, busy, done);
            end
            a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
            a_in = a; b_in = b; cin = c;
            exp_q.push_back(model_add(a, b, c));
            bad_busy = 0;
            for (int j = 0; j < W; j++) begin
                @(negedge clk);
                if (busy !== 1'b1) bad_busy++;
                a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom_range(0, 1));
            end
            tests_run++;
            if (bad_busy != 0) begin
                tests_failed++;
                $display("FAIL b2b_busy_%0d: %0d cycles not busy, want 0", i, bad_busy);
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            tests_run++;
            if (done !== 1'b1 || {cout, sum_out} !== exp) begin
                tests_failed++;
                $display("FAIL b2b_result_%0d: done=%b got %h want done=1 %h",
                         i, done, {cout, sum_out}, exp);
            end
            prev_res = exp;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
    endtask

    // WIDTH=3: every a, b, cin.
    task automatic test_exhaustive_w3();
        int  n;
        int  bad;
        logic [3:0] exp;
        bad = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    exp = 4'(a) + 4'(b) + 4'(c);
                    @(negedge clk);
                    start3 = 1'b1; a3 = 3'(a); b3 = 3'(b); cin3 = 1'(c);
                    @(negedge clk);
                    start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom);
                    n = 0;
                    while (done3 !== 1'b1 && n < 20) begin
                        n++;
                        @(negedge clk);
                    end
                    tests_run++;
                    if (done3 !== 1'b1 || n != 3 || {cout3, sum3} !== exp) begin
                        tests_failed++;
                        bad++;
                        $display("FAIL w3_%0d_%0d_%0d: done=%b wait=%0d got %h want wait=3 %h",
                                 a, b, c, done3, n, {cout3, sum3}, exp);
                    end
                end
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        test_exhaustive_w3();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
